// File: rtl/key_event_responder_if.sv
// Avalon-MM slave bus plus interrupt line for the key event responder.
// The master drives address/strobes/writedata; the slave returns readdata and irq.
interface key_event_responder_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );
endinterface

// File: rtl/key_event_responder.sv
// Debounces active-low push buttons, latches press events into EDGE/COUNT
// registers and raises a maskable level interrupt over an Avalon-MM slave.
module key_event_responder #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_KEYS-1:0]          key_n,
  key_event_responder_if.slave       avs
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] stable_q;
  logic [CW-1:0]     cnt_q [N_KEYS];
  logic [N_KEYS-1:0] press;
  logic [15:0]       npress;
  logic [N_KEYS-1:0] mask_q;
  logic [N_KEYS-1:0] edge_q;
  logic [15:0]       count_q;
  logic [31:0]       readdata_q;
  logic [31:0]       rd_word;
  logic              wr_mask;
  logic              wr_edge;
  logic              wr_count;

  // Counter i runs only while key_n[i] disagrees with the debounced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_q <= '1;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (key_n[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == LAST) begin
          stable_q[i] <= ~stable_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // A press fires on the same edge the debounced level falls 1->0.
  always_comb begin
    press  = '0;
    npress = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      press[i] = stable_q[i] & ~key_n[i] & (cnt_q[i] == LAST);
      npress   = npress + 16'(press[i]);
    end
  end

  assign wr_mask  = avs.avs_write && (avs.avs_address == 2'd1);
  assign wr_edge  = avs.avs_write && (avs.avs_address == 2'd2);
  assign wr_count = avs.avs_write && (avs.avs_address == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q  <= '0;
      edge_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_mask) mask_q <= avs.avs_writedata[N_KEYS-1:0];
      if (wr_edge) edge_q <= (edge_q & ~avs.avs_writedata[N_KEYS-1:0]) | press;
      else         edge_q <= edge_q | press;
      if (wr_count) count_q <= npress;
      else          count_q <= count_q + npress;
    end
  end

  // Fixed read latency of one cycle, no waitrequest: a read strobe in cycle n
  // captures the pre-update register value, presented in cycle n+1 and held
  // until the next read strobe.
  always_comb begin
    rd_word = '0;
    case (avs.avs_address)
      2'd0: rd_word[N_KEYS-1:0] = ~stable_q;
      2'd1: rd_word[N_KEYS-1:0] = mask_q;
      2'd2: rd_word[N_KEYS-1:0] = edge_q;
      2'd3: rd_word[15:0]       = count_q;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)            readdata_q <= '0;
    else if (avs.avs_read) readdata_q <= rd_word;
  end

  assign avs.avs_readdata = readdata_q;
  assign avs.irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_key_event_responder.sv
// Bench for key_event_responder: directed register scenarios plus random key
// and bus traffic compared every cycle against a behavioural model.
module tb_key_event_responder;
  localparam int NK = 3;
  localparam int DB = 4;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_n;
  logic          preload;
  logic          chk_en;
  int            n_checks;
  int            n_fail;

  key_event_responder_if bus ();

  key_event_responder #(.N_KEYS(NK), .DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .avs   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: a key's level flips once DB consecutive samples disagree
  logic [NK-1:0] m_stable;
  logic [NK-1:0] m_mask;
  logic [NK-1:0] m_edge;
  logic [15:0]   m_count;
  logic [31:0]   m_rd;
  logic [NK-1:0] m_press;
  int            m_run [NK];

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      2'd0: v[NK-1:0] = ~m_stable;
      2'd1: v[NK-1:0] = m_mask;
      2'd2: v[NK-1:0] = m_edge;
      default: v[15:0] = m_count;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_stable = '1;
      m_mask   = '0;
      m_edge   = '0;
      m_count  = '0;
      m_rd     = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
    end else begin
      if (bus.avs_read) m_rd = model_read(bus.avs_address);
      m_press = '0;
      for (int k = 0; k < NK; k++) begin
        if (key_n[k] == m_stable[k]) m_run[k] = 0;
        else begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == DB) begin
            if (m_stable[k]) m_press[k] = 1'b1;
            m_stable[k] = ~m_stable[k];
            m_run[k] = 0;
          end
        end
      end
      if (preload) m_count = 16'hFFFF;
      else if (bus.avs_write && bus.avs_address == 2'd3) m_count = 16'($countones(m_press));
      else m_count = m_count + 16'($countones(m_press));
      if (bus.avs_write && bus.avs_address == 2'd1) m_mask = bus.avs_writedata[NK-1:0];
      if (bus.avs_write && bus.avs_address == 2'd2) m_edge = m_edge & ~bus.avs_writedata[NK-1:0];
      m_edge = m_edge | m_press;
    end
  end

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_readdata", bus.avs_readdata, m_rd);
      chk("model_irq", {31'd0, bus.irq}, {31'd0, |(m_edge & m_mask)});
    end
  end

  // driver tasks: each starts just after a falling edge and ends on one
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_write = 1'b1; bus.avs_address = a; bus.avs_writedata = d;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.avs_read = 1'b1; bus.avs_address = a;
    @(negedge clk);
    bus.avs_read = 1'b0;
    chk(name, bus.avs_readdata, exp);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0; preload = 1'b0;
    rst_n = 1'b0; key_n = '1;
    bus.avs_address = 2'd0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = 32'd0;
    idle(2);
    chk_en = 1'b1;
    chk("reset_readdata", bus.avs_readdata, 32'd0);
    chk("reset_irq", {31'd0, bus.irq}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // debounce: 3 low cycles rejected, 4 accepted
    key_n = 3'b110; idle(3); key_n = 3'b111; idle(2);
    rd(2'd0, 32'h0, "short_state");
    rd(2'd2, 32'h0, "short_edge");
    key_n = 3'b110; idle(4);
    rd(2'd0, 32'h1, "press_state");
    rd(2'd2, 32'h1, "press_edge");
    rd(2'd3, 32'h1, "press_count");
    key_n = 3'b111; idle(6);

    // interrupt masking
    wr(2'd1, 32'h2);
    wr(2'd2, 32'h1);
    key_n = 3'b101; idle(6);
    chk("irq_set", {31'd0, bus.irq}, 32'd1);
    key_n = 3'b111; idle(6);
    wr(2'd2, 32'h2);
    chk("irq_clear", {31'd0, bus.irq}, 32'd0);
    key_n = 3'b110; idle(6);
    rd(2'd2, 32'h1, "masked_edge");
    chk("masked_irq", {31'd0, bus.irq}, 32'd0);
    key_n = 3'b111; idle(6);
    wr(2'd2, 32'h7);

    // set wins over same-cycle clear on key 2
    key_n = 3'b011; idle(3);
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h4, "set_over_clear");
    key_n = 3'b111; idle(6);
    wr(2'd2, 32'h7);

    // COUNT wrap with two simultaneous presses
    preload = 1'b1;
    force dut.count_q = 16'hFFFF;
    idle(1);
    release dut.count_q;
    preload = 1'b0;
    rd(2'd3, 32'hFFFF, "preload_count");
    key_n = 3'b010; idle(6);
    rd(2'd3, 32'h1, "wrap_count");
    chk("hold_readdata", bus.avs_readdata, 32'h1);
    idle(1);
    chk("hold_readdata_n2", bus.avs_readdata, 32'h1);
    rd(2'd2, 32'h5, "dual_edge");
    key_n = 3'b111; idle(6);
    wr(2'd2, 32'h7);

    // reset mid-operation with key 1 held
    wr(2'd1, 32'h3);
    key_n = 3'b100; idle(6);
    key_n = 3'b101; idle(2);
    chk("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    chk("post_reset_irq", {31'd0, bus.irq}, 32'd0);
    chk("post_reset_readdata", bus.avs_readdata, 32'd0);
    rd(2'd0, 32'h0, "rst_state_p1");
    rd(2'd2, 32'h0, "rst_edge_p2");
    rd(2'd3, 32'h0, "rst_count_p3");
    rd(2'd0, 32'h0, "rst_state_p4");
    rd(2'd0, 32'h2, "rst_state_p5");
    rd(2'd2, 32'h2, "rst_edge_p6");
    rd(2'd3, 32'h1, "rst_count_p7");
    rd(2'd1, 32'h0, "rst_mask_p8");
    key_n = 3'b111; idle(6);

    // random key and bus traffic
    for (int t = 0; t < 400; t++) begin
      key_n = NK'($urandom_range(0, 7));
      for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
        case ($urandom_range(0, 3))
          0: begin bus.avs_read = 1'b1; bus.avs_address = 2'($urandom_range(0, 3)); end
          1: begin
            bus.avs_write = 1'b1; bus.avs_address = 2'($urandom_range(0, 3));
            bus.avs_writedata = $urandom;
          end
          default: ;
        endcase
        @(negedge clk);
        bus.avs_read = 1'b0; bus.avs_write = 1'b0;
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
